// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter (CPU = 0, debug loader = 1) with registered outputs.
// Define DMEM_ARB_FIXED_PRIO_EN for fixed priority to requester 0; the default build uses round-robin.
module dmem_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;

  state_t              state_q, state_d;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic                lat_id;
  logic                latch_en;
  logic                win_id;
  logic                tie_id;
  logic                cap_q, cap_d;
  logic                mem_en_d, mem_we_d, gnt0_d, gnt1_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_d;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign tie_id = 1'b0;
`else
  logic last_grant;
  assign tie_id = ~last_grant;
`endif

  always_comb begin
    state_d     = state_q;
    latch_en    = 1'b0;
    win_id      = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    cap_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          latch_en = 1'b1;
          win_id   = (req0 && req1) ? tie_id : req1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        mem_en_d    = 1'b1;
        mem_we_d    = lat_we;
        mem_addr_d  = lat_addr;
        mem_wdata_d = lat_wdata;
        gnt0_d      = ~lat_id;
        gnt1_d      = lat_id;
        state_d     = lat_we ? IDLE : RDWAIT;
      end
      RDWAIT: begin
        // Strobe becomes visible this cycle, so memory data arrives next cycle; cap_q delays the capture.
        cap_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_id    <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        lat_we    <= win_id ? we1 : we0;
        lat_addr  <= win_id ? addr1 : addr0;
        lat_wdata <= win_id ? wdata1 : wdata0;
        lat_id    <= win_id;
`ifndef DMEM_ARB_FIXED_PRIO_EN
        last_grant <= win_id;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      cap_q     <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      gnt0      <= gnt0_d;
      gnt1      <= gnt1_d;
      cap_q     <= cap_d;
      // lat_id still names the read's owner here; a new latch lands on this same edge.
      rvalid0   <= cap_q && !lat_id;
      rvalid1   <= cap_q && lat_id;
      if (cap_q) begin
        if (lat_id) rdata1 <= mem_rdata;
        else        rdata0 <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a one-cycle-latency memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, we0, req1, we1;
  logic [3:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0] rdata0, rdata1;
  logic        mem_en, mem_we;
  logic [3:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [15:0] mem [16];

  int errors = 0;
  int checks = 0;

  dmem_arbiter #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk(clk), .reset(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: en=%b we=%b a=%h wd=%h g=%b%b rv=%b%b rd0=%h rd1=%h required all 0",
               mem_en, mem_we, mem_addr, mem_wdata, gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write();
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd3; wdata0 = 16'hBEEF;
    tick();
    checks++;
    if (gnt0 !== 1'b0) begin errors++; $display("FAIL wr_gnt_early: gnt0=%b required 0", gnt0); end
    tick();
    checks++;
    if ({gnt0, gnt1, mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 16'hBEEF}) begin
      errors++;
      $display("FAIL wr_issue: g0=%b g1=%b en=%b we=%b a=%h wd=%h required 1 0 1 1 3 beef",
               gnt0, gnt1, mem_en, mem_we, mem_addr, mem_wdata);
    end
    req0 = 1'b0; we0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({gnt0, gnt1, mem_en, rvalid0, rvalid1} !== 5'b0) begin
        errors++;
        $display("FAIL wr_quiet: cyc=%0d g=%b%b en=%b rv=%b%b required all 0", i, gnt0, gnt1, mem_en, rvalid0, rvalid1);
      end
    end
  endtask

  task automatic test_read();
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'd3;
    tick();
    tick();
    checks++;
    if ({gnt1, gnt0, mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 1'b1, 1'b0, 4'd3}) begin
      errors++;
      $display("FAIL rd_issue: g1=%b g0=%b en=%b we=%b a=%h required 1 0 1 0 3", gnt1, gnt0, mem_en, mem_we, mem_addr);
    end
    req1 = 1'b0;
    tick();
    checks++;
    if (rvalid1 !== 1'b0) begin errors++; $display("FAIL rd_rvalid_early: rvalid1=%b required 0", rvalid1); end
    tick();
    checks++;
    if ({rvalid1, rvalid0, rdata1} !== {1'b1, 1'b0, 16'hBEEF}) begin
      errors++;
      $display("FAIL rd_data: rv1=%b rv0=%b rdata1=%h required 1 0 beef", rvalid1, rvalid0, rdata1);
    end
    checks++;
    if (rdata0 !== 16'h0000) begin errors++; $display("FAIL rd_other_data: rdata0=%h required 0000", rdata0); end
    tick();
    checks++;
    if ({rvalid1, rdata1} !== {1'b0, 16'hBEEF}) begin
      errors++;
      $display("FAIL rd_hold: rv1=%b rdata1=%h required 0 beef", rvalid1, rdata1);
    end
  endtask

  task automatic test_tie_rr();
    logic e0, e1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'd3;
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'd3;
    for (int i = 1; i <= 12; i++) begin
      tick();
`ifdef DMEM_ARB_FIXED_PRIO_EN
      e0 = (i == 2 || i == 5 || i == 8 || i == 11);
      e1 = 1'b0;
`else
      e0 = (i == 2 || i == 8);
      e1 = (i == 5 || i == 11);
`endif
      checks++;
      if ({gnt0, gnt1} !== {e0, e1}) begin
        errors++;
        $display("FAIL tie_order: cyc=%0d gnt0=%b gnt1=%b required %b %b", i, gnt0, gnt1, e0, e1);
      end
      checks++;
      if ((int'(gnt0) + int'(gnt1) + int'(rvalid0) + int'(rvalid1)) > 1 || mem_en !== (gnt0 | gnt1)) begin
        errors++;
        $display("FAIL tie_exclusive: cyc=%0d en=%b g=%b%b rv=%b%b required at most one, en only with gnt",
                 i, mem_en, gnt0, gnt1, rvalid0, rvalid1);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_reset_rdwait();
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'd3;
    tick();
    tick();
    checks++;
    if (gnt0 !== 1'b1) begin errors++; $display("FAIL rst_pre_gnt: gnt0=%b required 1", gnt0); end
    req0 = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: en=%b g=%b%b rv=%b%b rd0=%h rd1=%h required all 0",
               mem_en, gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({rvalid0, rvalid1, gnt0, mem_en} !== 4'b0) begin
        errors++;
        $display("FAIL rst_no_rvalid: cyc=%0d rv=%b%b g0=%b en=%b required all 0", i, rvalid0, rvalid1, gnt0, mem_en);
      end
    end
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    tick();
    tick();
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL rst_first_tie: gnt0=%b gnt1=%b required 1 0", gnt0, gnt1);
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_late_req();
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd7; wdata0 = 16'h1234;
    tick();
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'd7;
    tick();
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin errors++; $display("FAIL late_g0: gnt0=%b gnt1=%b required 1 0", gnt0, gnt1); end
    req0 = 1'b0; we0 = 1'b0;
    tick();
    checks++;
    if ({gnt0, gnt1} !== 2'b00) begin errors++; $display("FAIL late_gap: gnt0=%b gnt1=%b required 0 0", gnt0, gnt1); end
    tick();
    checks++;
    if ({gnt1, mem_en, mem_we, mem_addr} !== {1'b1, 1'b1, 1'b0, 4'd7}) begin
      errors++;
      $display("FAIL late_g1: g1=%b en=%b we=%b a=%h required 1 1 0 7", gnt1, mem_en, mem_we, mem_addr);
    end
    req1 = 1'b0;
    tick();
    tick();
    checks++;
    if ({rvalid1, rdata1} !== {1'b1, 16'h1234}) begin
      errors++;
      $display("FAIL late_rdata: rv1=%b rdata1=%h required 1 1234", rvalid1, rdata1);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    mem_rdata = 16'h0000;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    test_reset();
    test_write();
    test_read();
    test_tie_rr();
    test_reset_rdwait();
    test_late_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
